// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressed data memory with valid/ready request and response channels.
// Implements RV32I load/store widths, sign extension and alignment checks.
module data_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [7:0]  mem_q [Depth];

    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic              access_err;
    logic [3:0]        be;
    logic [31:0]       load_val;
    logic [7:0]        lbyte;
    logic [15:0]       lhalf;

    // Reset gates ready so no request can be taken while reset is held.
    assign req_ready_o = (state_q == StIdle) && rst_ni;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign accept = req_valid_i && req_ready_o;
    assign commit = (state_q == StWait) && (cnt_q == 4'd0);

    // Aligned accesses never wrap, so the ADDR_W-bit increments are safe.
    assign a0 = addr_q[ADDR_W-1:0];
    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);
    assign lbyte = mem_q[a0];
    assign lhalf = {mem_q[a1], mem_q[a0]};

    // Decode the latched request into byte enables, load result and error flag.
    always_comb begin
        access_err = |addr_q[31:ADDR_W];
        be         = 4'b0000;
        load_val   = 32'h0;
        if (we_q) begin
            case (funct3_q)
                3'b000: be = 4'b0001;
                3'b001: if (addr_q[0]) access_err = 1'b1; else be = 4'b0011;
                3'b010: if (addr_q[1:0] != 2'b00) access_err = 1'b1; else be = 4'b1111;
                default: access_err = 1'b1;
            endcase
        end else begin
            case (funct3_q)
                3'b000: load_val = {{24{lbyte[7]}}, lbyte};
                3'b100: load_val = {24'h0, lbyte};
                3'b001: if (addr_q[0]) access_err = 1'b1;
                        else load_val = {{16{lhalf[15]}}, lhalf};
                3'b101: if (addr_q[0]) access_err = 1'b1; else load_val = {16'h0, lhalf};
                3'b010: if (addr_q[1:0] != 2'b00) access_err = 1'b1;
                        else load_val = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
                default: access_err = 1'b1;
            endcase
        end
        if (access_err) begin
            be       = 4'b0000;
            load_val = 32'h0;
        end
    end

    // Next-state logic for the request/wait/response sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = load_val;
                    err_d   = access_err;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture request fields at acceptance; later changes on req_* are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else if (accept) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
        end
    end

    // Storage is not reset; stores commit on the WAIT-exit edge.
    always_ff @(posedge clk_i) begin
        if (commit) begin
            if (be[0]) mem_q[a0] <= wdata_q[7:0];
            if (be[1]) mem_q[a1] <= wdata_q[15:8];
            if (be[2]) mem_q[a2] <= wdata_q[23:16];
            if (be[3]) mem_q[a3] <= wdata_q[31:24];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for function/errors/
// backpressure/reset, LATENCY=1 instance for latency and throughput.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        l1_req_valid = 1'b0, l1_req_we = 1'b0, l1_rsp_ready = 1'b0;
    logic [2:0]  l1_req_funct3 = 3'b000;
    logic [31:0] l1_req_addr = 32'h0, l1_req_wdata = 32'h0;
    logic        l1_req_ready, l1_rsp_valid, l1_rsp_err;
    logic [31:0] l1_rsp_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err)
    );

    data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(l1_req_valid), .req_ready_o(l1_req_ready), .req_we_i(l1_req_we),
        .req_funct3_i(l1_req_funct3), .req_addr_i(l1_req_addr), .req_wdata_i(l1_req_wdata),
        .rsp_valid_o(l1_rsp_valid), .rsp_ready_i(l1_rsp_ready), .rsp_rdata_o(l1_rsp_rdata),
        .rsp_err_o(l1_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+#1 with the DUT idle; returns at accept edge + #1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0;
        req_wdata = 32'h0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic finish_rsp(input string tag, input logic [31:0] exp_rd, input logic exp_err);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_vld_clr"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        issue(we, f3, addr, wd, tag);
        wait_rsp(tag, 2);
        finish_rsp(tag, exp_rd, exp_err);
    endtask

    initial begin
        logic [8:0] pat;
        int n;

        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Basic store/load and width/extension
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");
        txn(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb13");
        txn(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu13");
        txn(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh12");
        txn(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu10");
        txn(1'b1, 3'b000, 32'h11, 32'h12345655, 32'h0, 1'b0, "sb11");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_sb");
        txn(1'b1, 3'b001, 32'h12, 32'h0000A5A5, 32'h0, 1'b0, "sh12");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A555EF, 1'b0, "lw_sh");

        // Illegal accesses
        txn(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, "lw_mis");
        txn(1'b1, 3'b010, 32'h400, 32'h77777777, 32'h0, 1'b1, "sw_oor");
        txn(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "ld_f3_011");
        txn(1'b1, 3'b001, 32'h11, 32'h99999999, 32'h0, 1'b1, "sh_mis");
        txn(1'b1, 3'b011, 32'h10, 32'h88888888, 32'h0, 1'b1, "st_f3_011");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A555EF, 1'b0, "lw_after_err");

        // Backpressure: response held, a new request waits until after handshake
        issue(1'b0, 3'b010, 32'h10, 32'h0, "bp_lw");
        wait_rsp("bp_lw", 2);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hA5A555EF);
            chk("bp_err", 32'(rsp_err), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_hs_valid", 32'(rsp_valid), 32'd0);
        chk("bp_hs_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_acc_ready", 32'(req_ready), 32'd0);
        wait_rsp("bp_sw", 2);
        finish_rsp("bp_sw", 32'h0, 1'b0);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, "lw_bp");

        // Reset while a store waits with counter = 1
        txn(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, "sw20_zero");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, "lw_pre_rst");
        issue(1'b1, 3'b010, 32'h20, 32'h11111111, "sw20_abort");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("mid_rst_rel_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        txn(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, "lw20_after_rst");

        // LATENCY = 1 instance
        l1_req_we = 1'b1; l1_req_funct3 = 3'b010; l1_req_addr = 32'h4;
        l1_req_wdata = 32'h01020304; l1_req_valid = 1'b1;
        chk("l1_rdy", 32'(l1_req_ready), 32'd1);
        @(posedge clk); #1;
        l1_req_valid = 1'b0;
        n = 0;
        while (!l1_rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("l1_lat", 32'(n), 32'd1);
        chk("l1_sw_rdata", l1_rsp_rdata, 32'h0);
        l1_rsp_ready = 1'b1;
        @(posedge clk); #1;
        l1_req_we = 1'b0; l1_req_funct3 = 3'b010; l1_req_addr = 32'h4; l1_req_wdata = 32'h0;
        l1_req_valid = 1'b1;
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            pat[i] = l1_rsp_valid;
            if (i == 1) chk("l1_stream_rdata", l1_rsp_rdata, 32'h01020304);
        end
        l1_req_valid = 1'b0;
        chk("l1_stream_pat", 32'(pat), 32'h092);
        @(posedge clk); @(posedge clk); #1;
        l1_rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder that serves load/store requests from the RV32 core over a valid/ready request channel and a valid/ready response channel.
- Replaces the single-cycle combinational data memory on the memory side of the load/store path.
- Byte-addressed, little-endian storage.
- Implements RV32I load/store width, sign-extension and alignment rules; reports illegal accesses on `rsp_err`.

Parameters:
- ADDR_W, 10, byte-address width of storage; capacity is 2**ADDR_W bytes.
- LATENCY, 2, rising edges from the accepting edge to `rsp_valid` high; legal range 1..15.

Ports:
- CLK  in  1  clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes used for SB/SH.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
- rsp_err  out  1  access illegal; no memory update performed.

Behaviour:
- Reset = 0 (async): state IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0, req_ready = 0 while Reset = 0.
  - Storage is not cleared by reset; simulation initialises it to 0 at time 0.
- States:
  - IDLE: req_ready = 1. On req_valid && req_ready at an edge, latch we/funct3/addr/wdata, load counter = LATENCY-1, go to WAIT.
  - WAIT: req_ready = 0. If counter != 0, decrement. If counter == 0, perform the access at this edge, register rsp_rdata/rsp_err, set rsp_valid = 1, go to RESP.
  - RESP: req_ready = 0; rsp_valid, rsp_rdata and rsp_err held stable. On rsp_valid && rsp_ready at an edge, clear rsp_valid, go to IDLE.
- Timing:
  - Accept at edge E0 gives rsp_valid high after edge E0+LATENCY.
  - Minimum request-to-request spacing is LATENCY+2 cycles: 1 accept, LATENCY wait, 1 response handshake.
  - req_ready rises the cycle after the response handshake. There is no same-cycle response/accept overlap.
- req_* inputs are ignored when req_ready = 0. Request fields are used only as latched at acceptance.
- Loads (req_we = 0):
  - 000 LB: sign-extend byte[a].
  - 001 LH: sign-extend {byte[a+1], byte[a]}.
  - 010 LW: {b[a+3], b[a+2], b[a+1], b[a]}.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Stores (req_we = 1):
  - 000 SB: write wdata[7:0] to byte a.
  - 001 SH: write wdata[15:0] to bytes a..a+1.
  - 010 SW: write all 4 bytes.
  - Stores commit at the WAIT-exit edge. Response has rsp_rdata = 0.
- Error conditions (any one sets rsp_err = 1, rsp_rdata = 0, no write):
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - addr >= 2**ADDR_W, i.e. any set bit above ADDR_W-1.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
- Reset mid-operation: a store whose commit edge has not occurred is dropped; a pending response is discarded.

Test Plan:
- LATENCY = 2. SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid exactly 2 edges after each accept; rdata 0xDEADBEEF; err 0; store response rdata 0.
- After the above, loads:
  - LB @0x13 -> 0xFFFFFFDE
  - LBU @0x13 -> 0x000000DE
  - LH @0x12 -> 0xFFFFDEAD
  - LHU @0x10 -> 0x0000BEEF
- SB @0x11 wdata 0x12345655, then LW @0x10 -> 0xDEAD55EF. SH @0x12 wdata 0x0000A5A5, then LW @0x10 -> 0xA5A555EF.
- Error cases:
  - LW @0x12 -> err 1, rdata 0.
  - SW @0x400 (ADDR_W = 10) -> err 1.
  - Load funct3 011 -> err 1.
  - Subsequent LW @0x10 unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP while driving req_valid = 1 with different fields -> rsp_valid/rdata/err stable, req_ready = 0, the new request is only accepted the cycle after the response handshake.
- Drive Reset = 0 for 1 cycle while an SW 0x11111111 @0x20 is in WAIT with counter = 1 -> outputs zero immediately; after release req_ready = 1; LW @0x20 returns the prior value 0x00000000.
- LATENCY = 1 build: accept at E0 -> rsp_valid after E1; back-to-back LW stream with rsp_ready = 1 gives one response every 3 cycles.
